sr_ctrl: RTL
============

Name: sr_ctrl

Overview:
- Owns the 16-bit status register (SR) and decides which source updates it each cycle: ALU flag updates, explicit register-file writes to SR, interrupt entry and RETI restore.
- Sequences the SR save/clear on interrupt entry and the SR restore on RETI through a small FSM with a stack-port handshake.
- Sits beside the SR input mux, between the instruction decoder/ALU and the register file.
- Exports the effective GIE and low-power bits to the interrupt and clock logic.

Parameters:
- SR_RST, 16'h0000, SR value loaded at reset.
- SR_WMASK, 16'h01FF, writable bits; all other bits always read 0.
- IRQ_KEEP_MASK, 16'h0040, SR bits preserved on interrupt entry (SCG0); all others cleared.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- alu_flags_valid  in  1  ALU result this cycle updates flags
- alu_flags  in  4  {V,N,Z,C}
- alu_flags_mask  in  4  per-flag update enable, same order
- reg_wr_en  in  1  register-file write targets SR
- reg_wr_data  in  16  data for that write
- instr_done  in  1  pulse at each instruction retire
- irq_take  in  1  pulse: interrupt accepted, begin entry
- reti_start  in  1  pulse: RETI decoded, begin restore
- push_valid  out  1  SR save word valid
- push_data  out  16  SR save word
- push_ready  in  1  stack accepts push
- pop_valid  in  1  popped SR word valid
- pop_data  in  16  popped SR word
- sr_out  out  16  current SR
- gie_eff  out  1  effective global interrupt enable
- cpu_off  out  1  SR[4]
- busy  out  1  FSM not in RUN; decoder stalls

Behaviour:
- Bit map: C=0, Z=1, N=2, GIE=3, CPUOFF=4, OSCOFF=5, SCG0=6, SCG1=7, V=8.
- Every SR write is ANDed with SR_WMASK.
- Reset (async, rst_n low): sr_out=SR_RST&SR_WMASK, state=RUN, push_valid=0, gie_eff=0, busy=0. Reset mid-sequence aborts it; no push completes.
- FSM states:
  - RUN: SR updates are accepted.
  - SAVE: push_valid=1 and push_data=SR, held stable until push_ready. On handshake, go to CLR.
  - CLR: SR &= IRQ_KEEP_MASK, then return to RUN (one cycle).
  - RESTORE: wait for pop_valid; load SR from pop_data, then return to RUN.
- busy=1 in SAVE, CLR and RESTORE.
- RUN priority, highest first:
  1. irq_take: go to SAVE; same-cycle SR updates are discarded.
  2. reti_start: go to RESTORE.
  3. reg_wr_en: SR=reg_wr_data. Overrides ALU flags in the same cycle.
  4. alu_flags_valid: bits whose mask bit is 1 take the new value; others hold.
- irq_take/reti_start outside RUN are ignored. irq_take while gie_eff=0 is still honoured; qualification belongs to the interrupt controller.
- All SR updates become visible on sr_out the cycle after the update cycle.
- gie_eff:
  - Falls in the same cycle SR.GIE is written 0.
  - After a 0→1 write, rises at the second instr_done following the write, so the EINT-following instruction runs with interrupts still masked.
  - A RESTORE that sets GIE makes gie_eff rise in the restore cycle.
- cpu_off=sr_out[4], combinational.

Optional Feature:
- Macro: SR_GIE_DELAY_EN.
- Defined: gie_eff uses the delayed-enable rule above.
- Undefined: gie_eff=sr_out[3], no delay counter is built, and instr_done is unused.

Decomposition:
- Shared package msp_sr_pkg holds:
  - SR bit index constants: SR_C, SR_Z, SR_N, SR_GIE, SR_CPUOFF, SR_OSCOFF, SR_SCG0, SR_SCG1, SR_V.
  - The sr_state_t enum {RUN, SAVE, CLR, RESTORE}.
  - Default mask constants.
- Natural sub-module: sr_gie_delay (2-instruction retire counter for gie_eff), instantiated only under SR_GIE_DELAY_EN.

Test Plan:
- Reset, then alu_flags_valid with flags=4'b1011, mask=4'b0011 → sr_out=16'h0003; next update with flags=0, mask=4'b1000 → sr_out=16'h0003.
- Same cycle: reg_wr_en data=16'hFFFF plus alu_flags_valid → sr_out=16'h01FF; bits 15:9 stay 0.
- SR=16'h01D8, irq_take, push_ready low 3 cycles → push_data steady at 16'h01D8 and busy=1 throughout; after handshake, sr_out=16'h0040 and gie_eff=0.
- reti_start, pop_valid after 2 cycles with pop_data=16'h0008 → sr_out=16'h0008, gie_eff=1, busy falls.
- Delay build: reg write SR=16'h0008 → gie_eff stays 0 through first instr_done and rises at second. Non-delay build: rises the cycle after the write.
- rst_n asserted mid-SAVE → push_valid=0 immediately, sr_out=SR_RST, state RUN.

Source files
------------

// File: rtl/msp_sr_pkg.sv
// Shared status-register definitions: bit indices, FSM states and default masks.
package msp_sr_pkg;

  localparam int SR_C      = 0;
  localparam int SR_Z      = 1;
  localparam int SR_N      = 2;
  localparam int SR_GIE    = 3;
  localparam int SR_CPUOFF = 4;
  localparam int SR_OSCOFF = 5;
  localparam int SR_SCG0   = 6;
  localparam int SR_SCG1   = 7;
  localparam int SR_V      = 8;

  localparam logic [15:0] SR_RST_DEF        = 16'h0000;
  localparam logic [15:0] SR_WMASK_DEF      = 16'h01FF;
  localparam logic [15:0] IRQ_KEEP_MASK_DEF = 16'h0040;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    SAVE    = 2'd1,
    CLR     = 2'd2,
    RESTORE = 2'd3
  } sr_state_t;

  // Flags arrive as {V,N,Z,C}; only bits with a set mask bit are replaced.
  function automatic logic [15:0] applyFlags(input logic [15:0] sr,
                                             input logic [3:0]  flags,
                                             input logic [3:0]  mask);
    logic [15:0] res;
    res = sr;
    if (mask[0]) res[SR_C] = flags[0];
    if (mask[1]) res[SR_Z] = flags[1];
    if (mask[2]) res[SR_N] = flags[2];
    if (mask[3]) res[SR_V] = flags[3];
    return res;
  endfunction

endpackage

// File: rtl/sr_gie_delay.sv
// Delayed global-interrupt-enable: after GIE is set by a register write, the
// effective enable waits for two instruction retires. Used under SR_GIE_DELAY_EN.
module sr_gie_delay (
  input  logic clk,
  input  logic rst_n,
  input  logic instr_done_i,
  input  logic gie_set_i,
  input  logic gie_load_i,
  input  logic gie_clr_i,
  output logic gie_eff_o
);

  logic       gieEn_q,     gieEn_d;
  logic       giePend_q,   giePend_d;
  logic [1:0] retireCnt_q, retireCnt_d;

  always_comb begin
    gieEn_d     = gieEn_q;
    giePend_d   = giePend_q;
    retireCnt_d = retireCnt_q;
    if (gie_clr_i) begin
      gieEn_d     = 1'b0;
      giePend_d   = 1'b0;
      retireCnt_d = 2'd0;
    end else if (gie_load_i) begin
      gieEn_d   = 1'b1;
      giePend_d = 1'b0;
    end else if (gie_set_i) begin
      giePend_d   = 1'b1;
      retireCnt_d = 2'd0;
    end else if (giePend_q && instr_done_i) begin
      // The retire of the enabling instruction and the one after it.
      if (retireCnt_q == 2'd1) begin
        gieEn_d   = 1'b1;
        giePend_d = 1'b0;
      end else begin
        retireCnt_d = retireCnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gieEn_q     <= 1'b0;
      giePend_q   <= 1'b0;
      retireCnt_q <= 2'd0;
    end else begin
      gieEn_q     <= gieEn_d;
      giePend_q   <= giePend_d;
      retireCnt_q <= retireCnt_d;
    end
  end

  // A write clearing GIE masks interrupts in the same cycle.
  assign gie_eff_o = gieEn_q & ~gie_clr_i;

endmodule

// File: rtl/sr_ctrl.sv
// Status-register owner: source arbitration plus interrupt save/clear and RETI
// restore FSM. Define SR_GIE_DELAY_EN for the two-retire delayed GIE enable.
module sr_ctrl
  import msp_sr_pkg::*;
#(
  parameter logic [15:0] SR_RST        = SR_RST_DEF,
  parameter logic [15:0] SR_WMASK      = SR_WMASK_DEF,
  parameter logic [15:0] IRQ_KEEP_MASK = IRQ_KEEP_MASK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_flags_valid,
  input  logic [3:0]  alu_flags,
  input  logic [3:0]  alu_flags_mask,
  input  logic        reg_wr_en,
  input  logic [15:0] reg_wr_data,
  input  logic        instr_done,
  input  logic        irq_take,
  input  logic        reti_start,
  output logic        push_valid,
  output logic [15:0] push_data,
  input  logic        push_ready,
  input  logic        pop_valid,
  input  logic [15:0] pop_data,
  output logic [15:0] sr_out,
  output logic        gie_eff,
  output logic        cpu_off,
  output logic        busy
);

  sr_state_t   state_q, state_d;
  logic [15:0] sr_q, sr_d;
  logic        regWrite;
  logic        clrLoad;
  logic        restoreLoad;

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    regWrite    = 1'b0;
    clrLoad     = 1'b0;
    restoreLoad = 1'b0;
    push_valid  = 1'b0;
    busy        = 1'b1;
    unique case (state_q)
      RUN: begin
        busy = 1'b0;
        if (irq_take) begin
          state_d = SAVE;
        end else if (reti_start) begin
          state_d = RESTORE;
        end else if (reg_wr_en) begin
          regWrite = 1'b1;
          sr_d     = reg_wr_data & SR_WMASK;
        end else if (alu_flags_valid) begin
          sr_d = applyFlags(sr_q, alu_flags, alu_flags_mask) & SR_WMASK;
        end
      end
      SAVE: begin
        push_valid = 1'b1;
        if (push_ready) state_d = CLR;
      end
      CLR: begin
        clrLoad = 1'b1;
        sr_d    = sr_q & IRQ_KEEP_MASK & SR_WMASK;
        state_d = RUN;
      end
      RESTORE: begin
        if (pop_valid) begin
          restoreLoad = 1'b1;
          sr_d        = pop_data & SR_WMASK;
          state_d     = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      sr_q    <= SR_RST & SR_WMASK;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
    end
  end

  assign push_data = sr_q;
  assign sr_out    = sr_q;
  assign cpu_off   = sr_q[SR_CPUOFF];

`ifdef SR_GIE_DELAY_EN
  logic gieClr, gieSet, gieLoad;

  // Only register writes get the delayed enable; RETI re-enables at once.
  assign gieClr  = (regWrite | clrLoad | restoreLoad) & ~sr_d[SR_GIE];
  assign gieSet  = regWrite & sr_d[SR_GIE] & ~sr_q[SR_GIE];
  assign gieLoad = restoreLoad & sr_d[SR_GIE];

  sr_gie_delay u_gie_delay (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_done_i (instr_done),
    .gie_set_i    (gieSet),
    .gie_load_i   (gieLoad),
    .gie_clr_i    (gieClr),
    .gie_eff_o    (gie_eff)
  );
`else
  logic unused_instr_done;
  assign unused_instr_done = instr_done;
  assign gie_eff = sr_q[SR_GIE];
`endif

endmodule
